// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory block-port arbiter.
// Contents: default line geometry, the arbiter state encoding and the
// line-address alignment helper used when a grant latches an address.
package mem_arb_pkg;

  localparam int unsigned DEF_BLOCK_BITS  = 256;
  localparam int unsigned DEF_OFFSET_BITS = 5;

  // StIdle doubles as "no grant" in the grant selector output.
  typedef enum logic [2:0] {
    StIdle,
    StIRd,
    StDRd,
    StDWr,
    StResp
  } arb_state_e;

  // Clear the byte-offset bits so memory always sees a line-aligned address.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned off_bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_block_arbiter_if.sv
// Bundle of every non-clock/reset signal of the memory block arbiter.
// Cache side : i_req/i_addr -> i_done/i_block ; d_req/d_we/d_addr/d_wblock -> d_done/d_block
// Memory side: mem_addr/mem_blk_read/mem_blk_write/mem_wblock -> mem_rblock/mem_*_valid
// Status     : busy, timeout_err
// Modports   : master = the arbiter itself, slave = caches plus memory (the environment).
interface mem_block_arbiter_if import mem_arb_pkg::*; #(
  parameter int unsigned BLOCK_BITS = DEF_BLOCK_BITS
);

  logic                  i_req;
  logic [31:0]           i_addr;
  logic                  i_done;
  logic [BLOCK_BITS-1:0] i_block;

  logic                  d_req;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [BLOCK_BITS-1:0] d_wblock;
  logic                  d_done;
  logic [BLOCK_BITS-1:0] d_block;

  logic [31:0]           mem_addr;
  logic                  mem_blk_read;
  logic                  mem_blk_write;
  logic [BLOCK_BITS-1:0] mem_wblock;
  logic [BLOCK_BITS-1:0] mem_rblock;
  logic                  mem_read_valid;
  logic                  mem_write_valid;

  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wblock,
    input  mem_rblock, mem_read_valid, mem_write_valid,
    output i_done, i_block, d_done, d_block,
    output mem_addr, mem_blk_read, mem_blk_write, mem_wblock,
    output busy, timeout_err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wblock,
    output mem_rblock, mem_read_valid, mem_write_valid,
    input  i_done, i_block, d_done, d_block,
    input  mem_addr, mem_blk_read, mem_blk_write, mem_wblock,
    input  busy, timeout_err
  );

endinterface

// File: rtl/arb_grant_select.sv
// Combinational grant choice for an idle arbiter.
// Ports: i_d_req, i_d_we, i_i_req  - current request levels
//        i_streak_max             - D-cache has used up its consecutive-grant allowance
//        o_grant                  - StDWr/StDRd/StIRd, or StIdle when nothing to grant
module arb_grant_select import mem_arb_pkg::*; (
  input  logic       i_d_req,
  input  logic       i_d_we,
  input  logic       i_i_req,
  input  logic       i_streak_max,
  output arb_state_e o_grant
);

  always_comb begin
    o_grant = StIdle;
    // D wins unless a waiting I-fetch has been passed over too many times.
    if (i_d_req && !(i_i_req && i_streak_max)) begin
      o_grant = i_d_we ? StDWr : StDRd;
    end else if (i_i_req) begin
      o_grant = StIRd;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares the single main-memory block port between the I-cache (line reads)
// and the D-cache (line fills and write-backs), one transaction at a time.
// Ports: CLK, RESET (synchronous, active high)
//        io_bus - mem_block_arbiter_if.master carrying cache, memory and status signals
// D-cache has priority; after MAX_D_BURST consecutive D grants with an I request
// pending, the I-cache is served. A sticky timeout_err flags a slow memory.
module mem_block_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned BLOCK_BITS     = DEF_BLOCK_BITS,
  parameter int unsigned OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int unsigned MAX_D_BURST    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 CLK,
  input logic                 RESET,
  mem_block_arbiter_if.master io_bus
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_BURST + 1);
  localparam int unsigned WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_D_BURST);
  localparam logic [WAIT_W-1:0]   WaitMax   = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0]   WaitLast  = WAIT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e            r_state;
  arb_state_e            w_state_next;
  arb_state_e            w_grant;
  logic                  w_complete;

  logic [STREAK_W-1:0]   r_d_streak;
  logic [WAIT_W-1:0]     r_wait_cnt;

  logic                  r_i_done;
  logic                  r_d_done;
  logic [BLOCK_BITS-1:0] r_i_block;
  logic [BLOCK_BITS-1:0] r_d_block;
  logic [31:0]           r_mem_addr;
  logic                  r_mem_blk_read;
  logic                  r_mem_blk_write;
  logic [BLOCK_BITS-1:0] r_mem_wblock;
  logic                  r_busy;
  logic                  r_timeout_err;

  arb_grant_select u_grant_select (
    .i_d_req      (io_bus.d_req),
    .i_d_we       (io_bus.d_we),
    .i_i_req      (io_bus.i_req),
    .i_streak_max (r_d_streak == StreakMax),
    .o_grant      (w_grant)
  );

  // Only the valid that matches the outstanding request type ends a wait.
  always_comb begin
    w_complete = 1'b0;
    unique case (r_state)
      StIRd, StDRd: w_complete = io_bus.mem_read_valid;
      StDWr:        w_complete = io_bus.mem_write_valid;
      default:      w_complete = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:              w_state_next = w_grant;
      StIRd, StDRd, StDWr: if (w_complete) w_state_next = StResp;
      StResp:              w_state_next = StIdle;
      default:             w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= StIdle;
      r_d_streak      <= '0;
      r_wait_cnt      <= '0;
      r_i_done        <= 1'b0;
      r_d_done        <= 1'b0;
      r_i_block       <= '0;
      r_d_block       <= '0;
      r_mem_addr      <= '0;
      r_mem_blk_read  <= 1'b0;
      r_mem_blk_write <= 1'b0;
      r_mem_wblock    <= '0;
      r_busy          <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_busy   <= (w_state_next != StIdle);
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_grant == StIRd) begin
            r_mem_addr     <= line_align(io_bus.i_addr, OFFSET_BITS);
            r_mem_blk_read <= 1'b1;
            r_wait_cnt     <= '0;
          end else if (w_grant == StDRd) begin
            r_mem_addr     <= line_align(io_bus.d_addr, OFFSET_BITS);
            r_mem_blk_read <= 1'b1;
            r_wait_cnt     <= '0;
          end else if (w_grant == StDWr) begin
            r_mem_addr      <= line_align(io_bus.d_addr, OFFSET_BITS);
            r_mem_wblock    <= io_bus.d_wblock;
            r_mem_blk_write <= 1'b1;
            r_wait_cnt      <= '0;
          end

          // Streak counts D grants that overtook a pending I request.
          if (w_grant == StIRd || !io_bus.i_req) begin
            r_d_streak <= '0;
          end else if ((w_grant == StDRd || w_grant == StDWr) && r_d_streak != StreakMax) begin
            r_d_streak <= r_d_streak + 1'b1;
          end
        end

        StIRd, StDRd, StDWr: begin
          // Saturate so a stuck memory never wraps the counter.
          if (r_wait_cnt != WaitMax) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
          // Flag registers on the edge that takes the count to TIMEOUT_CYCLES.
          if (r_wait_cnt == WaitLast) begin
            r_timeout_err <= 1'b1;
          end
          if (w_complete) begin
            r_mem_blk_read  <= 1'b0;
            r_mem_blk_write <= 1'b0;
            if (r_state == StIRd) begin
              r_i_block <= io_bus.mem_rblock;
              r_i_done  <= 1'b1;
            end else if (r_state == StDRd) begin
              r_d_block <= io_bus.mem_rblock;
              r_d_done  <= 1'b1;
            end else begin
              r_d_done  <= 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign io_bus.i_done        = r_i_done;
  assign io_bus.i_block       = r_i_block;
  assign io_bus.d_done        = r_d_done;
  assign io_bus.d_block       = r_d_block;
  assign io_bus.mem_addr      = r_mem_addr;
  assign io_bus.mem_blk_read  = r_mem_blk_read;
  assign io_bus.mem_blk_write = r_mem_blk_write;
  assign io_bus.mem_wblock    = r_mem_wblock;
  assign io_bus.busy          = r_busy;
  assign io_bus.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed self-checking bench for mem_block_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_block_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned BB = 256;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_block_arbiter_if #(.BLOCK_BITS(BB)) bus ();

  mem_block_arbiter #(
    .BLOCK_BITS     (BB),
    .OFFSET_BITS    (5),
    .MAX_D_BURST    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .io_bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [BB-1:0] blk_a5;
  logic [BB-1:0] blk_5a;
  logic [BB-1:0] blk_3c;
  logic [BB-1:0] blk_c3;
  logic [BB-1:0] blk_96;
  logic [BB-1:0] blk_wr;
  logic [BB-1:0] blk_junk;

  task automatic idle_inputs();
    bus.i_req           = 1'b0;
    bus.i_addr          = '0;
    bus.d_req           = 1'b0;
    bus.d_we            = 1'b0;
    bus.d_addr          = '0;
    bus.d_wblock        = '0;
    bus.mem_rblock      = '0;
    bus.mem_read_valid  = 1'b0;
    bus.mem_write_valid = 1'b0;
  endtask

  // Bounded wait for a memory request to appear; ok=0 if it never does.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.mem_blk_read || bus.mem_blk_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_inputs();
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_tests++; if (bus.mem_blk_read !== 1'b0 || bus.mem_blk_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_req: got rd=%0b wr=%0b want 0 0", bus.mem_blk_read, bus.mem_blk_write); end
    n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    n_tests++; if (bus.i_done !== 1'b0 || bus.d_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got i=%0b d=%0b want 0 0", bus.i_done, bus.d_done); end
    n_tests++; if (bus.i_block !== '0 || bus.d_block !== '0 || bus.mem_wblock !== '0) begin
      n_fail++; $display("FAIL reset_blocks: got nonzero block registers, want 0"); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b want 0", bus.timeout_err); end
  endtask

  task automatic test_i_read();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0040_0013;
    @(negedge CLK);
    n_tests++; if (bus.mem_blk_read !== 1'b1) begin n_fail++; $display("FAIL iread_req: got %0b want 1", bus.mem_blk_read); end
    n_tests++; if (bus.mem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL iread_addr: got %h want 00400000", bus.mem_addr); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL iread_busy: got %0b want 1", bus.busy); end
    bus.i_req = 1'b0;
    @(negedge CLK);
    n_tests++; if (bus.i_done !== 1'b0) begin n_fail++; $display("FAIL iread_early_done: got %0b want 0", bus.i_done); end
    @(negedge CLK);
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_a5;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.i_done !== 1'b1) begin n_fail++; $display("FAIL iread_done: got %0b want 1", bus.i_done); end
    n_tests++; if (bus.i_block !== blk_a5) begin n_fail++; $display("FAIL iread_block: got %h want %h", bus.i_block, blk_a5); end
    n_tests++; if (bus.mem_blk_read !== 1'b0) begin n_fail++; $display("FAIL iread_req_drop: got %0b want 0", bus.mem_blk_read); end
    n_tests++; if (bus.d_done !== 1'b0) begin n_fail++; $display("FAIL iread_d_done: got %0b want 0", bus.d_done); end
    @(negedge CLK);
    n_tests++; if (bus.i_done !== 1'b0) begin n_fail++; $display("FAIL iread_pulse_len: got %0b want 0", bus.i_done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL iread_idle: got busy=%0b want 0", bus.busy); end
  endtask

  task automatic test_priority();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0040_1000;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h2000_0047;
    @(negedge CLK);
    n_tests++; if (bus.mem_addr !== 32'h2000_0040 || bus.mem_blk_read !== 1'b1) begin
      n_fail++; $display("FAIL prio_d_first: got addr=%h rd=%0b want 20000040 1", bus.mem_addr, bus.mem_blk_read); end
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_5a;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    bus.d_req          = 1'b0;
    n_tests++; if (bus.d_done !== 1'b1 || bus.i_done !== 1'b0) begin
      n_fail++; $display("FAIL prio_d_done: got d=%0b i=%0b want 1 0", bus.d_done, bus.i_done); end
    n_tests++; if (bus.d_block !== blk_5a) begin n_fail++; $display("FAIL prio_d_block: got %h want %h", bus.d_block, blk_5a); end
    @(negedge CLK);
    @(negedge CLK);
    n_tests++; if (bus.mem_addr !== 32'h0040_1000 || bus.mem_blk_read !== 1'b1) begin
      n_fail++; $display("FAIL prio_i_next: got addr=%h rd=%0b want 00401000 1", bus.mem_addr, bus.mem_blk_read); end
    bus.i_req          = 1'b0;
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_3c;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.i_done !== 1'b1 || bus.i_block !== blk_3c) begin
      n_fail++; $display("FAIL prio_i_done: got done=%0b blk=%h want 1 %h", bus.i_done, bus.i_block, blk_3c); end
    @(negedge CLK);
  endtask

  task automatic test_write_back();
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h1000_0020;
    bus.d_wblock = blk_wr;
    @(negedge CLK);
    bus.d_req = 1'b0;
    n_tests++; if (bus.mem_blk_write !== 1'b1 || bus.mem_blk_read !== 1'b0) begin
      n_fail++; $display("FAIL wb_req: got wr=%0b rd=%0b want 1 0", bus.mem_blk_write, bus.mem_blk_read); end
    n_tests++; if (bus.mem_addr !== 32'h1000_0020) begin n_fail++; $display("FAIL wb_addr: got %h want 10000020", bus.mem_addr); end
    n_tests++; if (bus.mem_wblock !== blk_wr) begin n_fail++; $display("FAIL wb_data: got %h want %h", bus.mem_wblock, blk_wr); end
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_junk;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.mem_blk_write !== 1'b1 || bus.d_done !== 1'b0) begin
      n_fail++; $display("FAIL wb_stray_valid: got wr=%0b done=%0b want 1 0", bus.mem_blk_write, bus.d_done); end
    @(negedge CLK);
    bus.mem_write_valid = 1'b1;
    @(negedge CLK);
    bus.mem_write_valid = 1'b0;
    n_tests++; if (bus.d_done !== 1'b1 || bus.mem_blk_write !== 1'b0) begin
      n_fail++; $display("FAIL wb_done: got done=%0b wr=%0b want 1 0", bus.d_done, bus.mem_blk_write); end
    n_tests++; if (bus.d_block !== blk_5a) begin n_fail++; $display("FAIL wb_d_block_kept: got %h want %h", bus.d_block, blk_5a); end
    @(negedge CLK);
    n_tests++; if (bus.d_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL wb_end: got done=%0b busy=%0b want 0 0", bus.d_done, bus.busy); end
  endtask

  // Both requests held: D,D,D,D,I then the streak restarts: D,D,D,D,I.
  task automatic test_starvation();
    bit ok;
    bit want_i;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_1000;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_2000;
    for (int g = 0; g < 10; g++) begin
      wait_grant(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL starve_grant%0d: got no grant want grant", g); end
      want_i = (g == 4 || g == 9);
      n_tests++; if (bus.mem_addr !== (want_i ? 32'h0000_1000 : 32'h0000_2000)) begin
        n_fail++; $display("FAIL starve_order%0d: got addr=%h want %h", g, bus.mem_addr,
                           want_i ? 32'h0000_1000 : 32'h0000_2000); end
      bus.mem_read_valid = 1'b1;
      bus.mem_rblock     = blk_3c;
      @(negedge CLK);
      bus.mem_read_valid = 1'b0;
      n_tests++; if (bus.i_done !== want_i || bus.d_done !== !want_i) begin
        n_fail++; $display("FAIL starve_done%0d: got i=%0b d=%0b want %0b %0b", g, bus.i_done, bus.d_done,
                           want_i, !want_i); end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_timeout();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0040;
    @(negedge CLK);
    bus.i_req = 1'b0;
    n_tests++; if (bus.mem_blk_read !== 1'b1) begin n_fail++; $display("FAIL to_req: got %0b want 1", bus.mem_blk_read); end
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK);
      if (j == 7) begin
        n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %0b want 0", bus.timeout_err); end
      end
      if (j == 8) begin
        n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_rise: got %0b want 1", bus.timeout_err); end
      end
    end
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_c3;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.i_done !== 1'b1 || bus.i_block !== blk_c3) begin
      n_fail++; $display("FAIL to_complete: got done=%0b blk=%h want 1 %h", bus.i_done, bus.i_block, blk_c3); end
    repeat (3) @(negedge CLK);
    n_tests++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0b want 1", bus.timeout_err); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_3000;
    @(negedge CLK);
    n_tests++; if (bus.mem_blk_read !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %0b want 1", bus.mem_blk_read); end
    RESET     = 1'b1;
    bus.d_req = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    n_tests++; if (bus.mem_blk_read !== 1'b0 || bus.busy !== 1'b0 || bus.d_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_clear: got rd=%0b busy=%0b done=%0b want 0 0 0",
                         bus.mem_blk_read, bus.busy, bus.d_done); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout: got %0b want 0", bus.timeout_err); end
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_junk;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.d_done !== 1'b0 || bus.d_block !== '0) begin
      n_fail++; $display("FAIL rst_mid_no_done: got done=%0b blk=%h want 0 0", bus.d_done, bus.d_block); end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0040_009F;
    wait_grant(ok);
    bus.i_req = 1'b0;
    n_tests++; if (!ok || bus.mem_addr !== 32'h0040_0080) begin
      n_fail++; $display("FAIL rst_mid_regrant: got ok=%0b addr=%h want 1 00400080", ok, bus.mem_addr); end
    bus.mem_read_valid = 1'b1;
    bus.mem_rblock     = blk_96;
    @(negedge CLK);
    bus.mem_read_valid = 1'b0;
    n_tests++; if (bus.i_done !== 1'b1 || bus.i_block !== blk_96) begin
      n_fail++; $display("FAIL rst_mid_serve: got done=%0b blk=%h want 1 %h", bus.i_done, bus.i_block, blk_96); end
    @(negedge CLK);
  endtask

  initial begin
    blk_a5   = {32{8'hA5}};
    blk_5a   = {32{8'h5A}};
    blk_3c   = {32{8'h3C}};
    blk_c3   = {32{8'hC3}};
    blk_96   = {32{8'h96}};
    blk_wr   = {8{32'h1234_5678}};
    blk_junk = {8{32'hDEAD_BEEF}};
    test_reset();
    test_i_read();
    test_priority();
    test_write_back();
    test_starvation();
    test_timeout();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
